// File: rtl/ps2_key_queue.sv
// ps2_key_queue: decodes PS/2 set-2 scan bytes (E0 extended prefix,
// F0 break prefix) into complete key events. The events go into a
// first-word-fall-through FIFO that the bus can poll and pop.
//
// Optional feature macro: KEY_QUEUE_DROP_BREAK_EN
//   defined   -> completed break (release) events are decoded but not queued
//   undefined -> make and break events are both queued
//
// Entry format: {release, extended, code[7:0]}.
module ps2_key_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        keycode,
  input  logic              keypress,
  input  logic              pop,
  input  logic              clr_overflow,
  output logic [9:0]        key_data,
  output logic              key_valid,
  output logic [ADDR_W:0]   count,
  output logic              overflow
);

  localparam logic [7:0]      PREFIX_EXT = 8'hE0;
  localparam logic [7:0]      PREFIX_BRK = 8'hF0;
  localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t              state_reg;
  logic                keypress_q;
  logic                accept;
  logic                is_ext_prefix;
  logic                is_brk_prefix;
  logic                event_release;
  logic                event_extended;
  logic                push_req;
  logic [9:0]          push_entry;

  logic [9:0]          mem [DEPTH];
  logic [ADDR_W-1:0]   wr_ptr_reg;
  logic [ADDR_W-1:0]   rd_ptr_reg;
  logic [ADDR_W:0]     count_reg;
  logic                overflow_reg;

  logic                fifo_full;
  logic                fifo_empty;
  logic                do_push;
  logic                do_pop;
  logic                drop_event;

  // A held keypress level produces exactly one accept on its rising edge.
  assign accept        = keypress & ~keypress_q;
  assign is_ext_prefix = (keycode == PREFIX_EXT);
  assign is_brk_prefix = (keycode == PREFIX_BRK);

  // Register the keypress level for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keypress_q <= 1'b0;
    end else begin
      keypress_q <= keypress;
    end
  end

  // Prefix-tracking decoder; only advances on an accepted byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else if (accept) begin
      case (state_reg)
        IDLE: begin
          if (is_ext_prefix)      state_reg <= EXT;
          else if (is_brk_prefix) state_reg <= BRK;
          else                    state_reg <= IDLE;
        end
        EXT: begin
          if (is_brk_prefix)      state_reg <= EXT_BRK;
          else if (is_ext_prefix) state_reg <= EXT;
          else                    state_reg <= IDLE;
        end
        BRK: begin
          if (is_ext_prefix)      state_reg <= EXT_BRK;
          else if (is_brk_prefix) state_reg <= BRK;
          else                    state_reg <= IDLE;
        end
        EXT_BRK: begin
          if (is_ext_prefix || is_brk_prefix) state_reg <= EXT_BRK;
          else                                state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Build the completed event from the current prefix state; prefixes never push.
  always_comb begin
    event_release  = (state_reg == BRK) || (state_reg == EXT_BRK);
    event_extended = (state_reg == EXT) || (state_reg == EXT_BRK);
    push_entry     = {event_release, event_extended, keycode};
`ifdef KEY_QUEUE_DROP_BREAK_EN
    // Break events are decoded (the FSM still returns to IDLE) but never queued,
    // so they can never cause an overflow either.
    push_req = accept && !is_ext_prefix && !is_brk_prefix && !event_release;
`else
    push_req = accept && !is_ext_prefix && !is_brk_prefix;
`endif
  end

  assign fifo_full  = (count_reg == FULL_COUNT);
  assign fifo_empty = (count_reg == '0);

  // Pop on empty is ignored. A pop while full frees the slot the push needs,
  // so both go ahead and the count stays at DEPTH.
  assign do_pop     = pop & ~fifo_empty;
  assign do_push    = push_req & (~fifo_full | do_pop);
  assign drop_event = push_req & fifo_full & ~do_pop;

  // Storage array, written at the tail; no reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Sticky overflow flag; a new drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_reg <= 1'b0;
    end else if (drop_event) begin
      overflow_reg <= 1'b1;
    end else if (clr_overflow) begin
      overflow_reg <= 1'b0;
    end
  end

  assign key_valid = ~fifo_empty;
  assign key_data  = fifo_empty ? 10'h000 : mem[rd_ptr_reg];
  assign count     = count_reg;
  assign overflow  = overflow_reg;

endmodule
